// File: rtl/regfile_scoreboard_if.sv
// Register-file port bundle: two read ports, one write-back port,
// one reservation port and the busy counter.
interface regfile_scoreboard_if #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5
);
  logic [ADDR_BITS-1:0] ra1;
  logic [ADDR_BITS-1:0] ra2;
  logic [WIDTH-1:0]     rd1;
  logic [WIDTH-1:0]     rd2;
  logic                 busy1;
  logic                 busy2;
  logic [ADDR_BITS-1:0] wa;
  logic [WIDTH-1:0]     wd;
  logic                 wrenable;
  logic [ADDR_BITS-1:0] rsv_addr;
  logic                 rsv_en;
  logic [ADDR_BITS:0]   busy_count;

  modport master (
    output ra1, ra2, wa, wd, wrenable,
    output rsv_addr, rsv_en,
    input  rd1, rd2, busy1, busy2, busy_count
  );

  modport slave (
    input  ra1, ra2, wa, wd, wrenable,
    input  rsv_addr, rsv_en,
    output rd1, rd2, busy1, busy2, busy_count
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy bits and a busy counter.
// Define REGFILE_BYPASS_EN to forward write-back data to read ports.
module regfile_scoreboard #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5
) (
  input logic                  clk,
  input logic                  reset,
  regfile_scoreboard_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] CNT_MAX =
    (ADDR_BITS+1)'(DEPTH - 1);

  logic [WIDTH-1:0]   regs [DEPTH];
  logic [DEPTH-1:0]   busy;
  logic [ADDR_BITS:0] cnt;
  logic               wr_ok;
  logic               rsv_ok;
  logic               set_new;
  logic               clr_old;

  assign wr_ok   = bus.wrenable && (bus.wa != '0);
  assign rsv_ok  = bus.rsv_en && (bus.rsv_addr != '0);
  assign set_new = rsv_ok && !busy[bus.rsv_addr];
  assign clr_old = wr_ok && busy[bus.wa] &&
                   !(rsv_ok && (bus.rsv_addr == bus.wa));

  // Data storage; register 0 is never written so it stays 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[bus.wa] <= bus.wd;
    end
  end

  // Busy bits: write-back clears, reservation sets and wins a tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (wr_ok)  busy[bus.wa]       <= 1'b0;
      if (rsv_ok) busy[bus.rsv_addr] <= 1'b1;
    end
  end

  // Busy counter tracks the net change of busy bits each edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (set_new && !clr_old && cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end else if (clr_old && !set_new && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign bus.busy_count = cnt;

  // Combinational read ports, optionally forwarding write-back.
  always_comb begin
    bus.rd1   = regs[bus.ra1];
    bus.busy1 = busy[bus.ra1];
    bus.rd2   = regs[bus.ra2];
    bus.busy2 = busy[bus.ra2];
`ifdef REGFILE_BYPASS_EN
    if (!reset && wr_ok && (bus.wa == bus.ra1)) begin
      bus.rd1   = bus.wd;
      bus.busy1 = rsv_ok && (bus.rsv_addr == bus.ra1);
    end
    if (!reset && wr_ok && (bus.wa == bus.ra2)) begin
      bus.rd2   = bus.wd;
      bus.busy2 = rsv_ok && (bus.rsv_addr == bus.ra2);
    end
`endif
  end
endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter WIDTH, default 32, data bits per register.
REQ-002 Parameter ADDR_BITS, default 5, address width; the register count DEPTH is 2**ADDR_BITS.
REQ-003 The block SHALL have one clock, clk, and its reset, reset, SHALL be asynchronous and active-high.
REQ-004 Ports:
  clk          in   1          rising-edge clock
  reset        in   1          asynchronous, active-high reset
  ra1          in   ADDR_BITS  read address, port 1
  ra2          in   ADDR_BITS  read address, port 2
  rd1          out  WIDTH      read data, port 1
  rd2          out  WIDTH      read data, port 2
  busy1        out  1          pending-write flag for ra1
  busy2        out  1          pending-write flag for ra2
  wa           in   ADDR_BITS  write-back address
  wd           in   WIDTH      write-back data
  wrenable     in   1          write-back strobe
  rsv_addr     in   ADDR_BITS  reservation address (issue stage)
  rsv_en       in   1          reservation strobe
  busy_count   out  ADDR_BITS+1  number of registers currently marked busy

Function
REQ-005 The block SHALL hold DEPTH registers of WIDTH bits and one busy bit per register.
REQ-006 Register 0 SHALL always read 0, ignore writes and reservations, and never be busy.
REQ-007 rd1/rd2 and busy1/busy2 SHALL be combinational from ra1/ra2 and the stored state, with no clock latency.
REQ-008 On a rising clk edge with wrenable=1 and wa!=0, reg[wa] SHALL take wd and busy[wa] SHALL clear.
REQ-009 On a rising clk edge with rsv_en=1 and rsv_addr!=0, busy[rsv_addr] SHALL set.
REQ-010 Same edge, wrenable and rsv_en, wa==rsv_addr!=0: data SHALL be written and busy SHALL remain 1 (the reservation wins).
REQ-011 Reserving an already-busy register SHALL leave it busy and leave busy_count unchanged.
REQ-012 A write-back to a non-busy register SHALL update its data and leave busy_count unchanged.
REQ-013 busy_count SHALL equal the number of set busy bits after every edge.
  Adjustment per edge is +1, -1 or 0 depending on the net change in busy bits.
  Maximum value is DEPTH-1.
  The count SHALL never wrap.
REQ-014 Read and write to the same address in one cycle SHALL return the old value, unless REQ-018 applies.

Reset
REQ-015 While reset=1, all registers SHALL be 0 and all busy bits SHALL be 0, regardless of clk.
  Consequently rd1=rd2=0, busy1=busy2=0 and busy_count=0.
REQ-016 Reset asserted mid-operation SHALL discard any write-back or reservation presented on the same edge.
REQ-017 After reset deasserts, the first rising edge SHALL process inputs normally.

Configuration
REQ-018 When macro REGFILE_BYPASS_EN is defined, a read port whose address equals wa (nonzero) while wrenable=1 SHALL behave as follows.
  It SHALL output wd combinationally.
  Its busy flag SHALL read 0, unless rsv_en=1 with rsv_addr equal to that address.
REQ-019 When REGFILE_BYPASS_EN is undefined, reads SHALL return only stored values and stored busy bits, as in REQ-014.

Verification
REQ-020 Reset, then read all addresses -> every rd = 0 and every busy = 0; busy_count = 0.
REQ-021 Write 32'hFFFAAA to reg 3, then read ra1=3 -> rd1 = 32'hFFFAAA; write with wrenable=0 of 32'hFFF000 -> rd1 still 32'hFFFAAA.
REQ-022 Write 32'h1234 to reg 0 and reserve reg 0 -> rd1 = 0, busy1 = 0, busy_count = 0.
REQ-023 Reserve regs 5, 6, 6 on consecutive edges -> busy_count = 2; write-back reg 5 -> busy_count = 1, busy[5] = 0; reserve and write-back reg 6 on the same edge -> busy[6] = 1, busy_count = 1.
REQ-024 With wa=7, wd=32'hBEEF, wrenable=1 and ra2=7 before the edge:
  With REGFILE_BYPASS_EN -> rd2 = 32'hBEEF.
  Without it -> rd2 = the old value.
REQ-025 Reserve reg 9, assert reset between edges -> busy_count = 0 immediately; a write-back on the next edge with reset held -> reg 9 remains 0.
